rr_dispatcher: RTL
==================

# rr_dispatcher

Round-robin work dispatcher for the SIMD multiprocessor fabric: takes one upstream stream of task words and hands each word to exactly one of N processing-element lanes. It is the 1-to-N counterpart of the N-to-1 round-robin arbiter. Instead of picking among valid requesters, it picks among available consumers, using strictly-rotating priority after the last lane served. Its output stage is a single registered beat with a one-hot target, so upstream sees a plain valid/ready sink.

## Interface
- N_DST, 8, number of destination lanes (≥2)
- DATA_W, 32, task word width
- SEQ_W, 8, sequence tag width (used only with RR_DISPATCH_SEQ_EN)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when in_valid && in_ready
- in_data  in  DATA_W  upstream task word
- dst_avail  in  N_DST  lane i can take new work (level, from PE)
- out_valid  out  N_DST  one-hot; bit i = beat offered to lane i
- out_ready  in  N_DST  lane i accepts; handshake on out_valid[i] && out_ready[i]
- out_data  out  DATA_W  shared data bus, valid for the lane flagged in out_valid
- out_seq  out  SEQ_W  sequence tag of held beat (only with RR_DISPATCH_SEQ_EN)

## Operation
- Output stage holds 0 or 1 beat: out_data and the one-hot target register (out_valid).
- Stage is "free" when out_valid == 0, or when the held beat is handshaken this cycle (out_valid & out_ready != 0).
- in_ready = free && (dst_avail != 0). It is combinational and must not depend on in_valid.
- On upstream handshake, load in_data and the target.
  - target = first set bit of dst_avail at index strictly above last_grant, wrapping from N_DST-1 to 0.
  - If the only available lane is last_grant itself, that lane is selected.
  - last_grant <= target.
- Target is fixed once loaded. out_valid and out_data stay stable until the handshake, regardless of dst_avail changes.
- If the held beat handshakes and there is no upstream load in the same cycle, out_valid goes to 0.
- out_ready bits of non-targeted lanes are ignored.
- dst_avail is sampled only in the load cycle.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_seq = 0.
  - last_grant = N_DST-1, so the first selection is lane 0.
  - in_ready follows the combinational rule above, i.e. it reads 1 once any dst_avail bit is set.
- Latency: upstream handshake at cycle t makes the beat visible on out_valid/out_data at t+1.
- Throughput: 1 beat/cycle when each targeted lane asserts out_ready in the cycle its beat is offered.
- Simultaneous drain and load: the new beat replaces the old one at the same edge, with no bubble.
- Backpressure: a held beat whose lane keeps out_ready low stalls in_ready. There is no bypass to other lanes; ordering is preserved.
- All dst_avail = 0: in_ready = 0, and pointer and stage are unchanged.
- Reset mid-operation: the held beat is discarded, out_valid = 0 from the next edge, and last_grant returns to N_DST-1.

## Configuration
- RR_DISPATCH_SEQ_EN defined:
  - SEQ_W-bit counter increments on every upstream handshake and wraps 2^SEQ_W-1 -> 0.
  - out_seq carries the counter value captured with the beat.
  - The first beat after reset has tag 0.
- Not defined: out_seq port, counter and associated registers are absent.

## Structure
- Package rr_dispatch_pkg:
  - default parameter constants.
  - onehot_to_idx function, used by the bench and for last_grant debug.
- Sub-module rr_select: combinational rotating-priority pick.
  - Inputs: avail[N], last[N] (one-hot).
  - Output: pick[N], one-hot or zero.
  - Implemented as a masked priority encoder plus an unmasked fallback encoder.
- Top: output stage registers, pointer register, optional sequence counter, in_ready logic.

## Test plan
- Reset, N_DST=8, dst_avail=8'hFF, 4 back-to-back words with out_ready all 1 -> out_valid sequence 01,02,04,08 starting the cycle after the first input handshake; no bubbles.
- last_grant=lane 2, dst_avail=8'b1000_0011 -> next target lane 7. Next word with same dst_avail -> lane 0 (wrap).
- dst_avail=8'b0000_0100 only, last_grant=lane 2 -> lane 2 reselected. Then dst_avail=0 -> in_ready=0 and the stage holds.
- Beat held for lane 5 with out_ready[5]=0 for 3 cycles, other out_ready=1 -> out_valid/out_data stable, in_ready=0 for 3 cycles; handshake in cycle 4 with in_valid=1 -> new beat loaded same edge.
- rst_n low for one cycle while a beat is held -> out_valid=0 next cycle, next selection lane 0, held data never delivered.
- With RR_DISPATCH_SEQ_EN and SEQ_W=2, 5 words -> out_seq 0,1,2,3,0.

Source files
------------

// File: rtl/rr_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_dispatch_pkg                                           |
// | Brief    : Default parameters and helpers for the rr_dispatcher.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package rr_dispatch_pkg;

    localparam int N_DST_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int SEQ_W_DEF  = 8;
    localparam int MAX_LANES  = 32;

    // Binary index of a one-hot vector; zero input yields index 0.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_LANES-1:0] oh);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_select                                                 |
// | Brief    : Rotating-priority pick of the first available lane above  |
// |            the last grant, wrapping to the lowest available lane.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_select #(
    parameter int N = 8
) (
    input  logic [N-1:0] avail,
    input  logic [N-1:0] last,
    output logic [N-1:0] pick
);

    logic [N-1:0] w_above;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_masked_pick;
    logic [N-1:0] w_any_pick;

    always_comb begin
        // Bits strictly above the one-hot last grant; empty when last is the MSB.
        w_above       = ~((last << 1) - N'(1));
        w_masked      = avail & w_above;
        w_masked_pick = w_masked & (~w_masked + N'(1));
        w_any_pick    = avail & (~avail + N'(1));
        pick          = (|w_masked) ? w_masked_pick : w_any_pick;
    end

endmodule
`default_nettype wire

// File: rtl/rr_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_dispatcher                                             |
// | Brief    : Round-robin 1-to-N task dispatcher with a single          |
// |            registered output beat and one-hot lane target.           |
// |            Optional sequence tagging: define RR_DISPATCH_SEQ_EN.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int N_DST  = N_DST_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef RR_DISPATCH_SEQ_EN
   ,parameter int SEQ_W  = SEQ_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [N_DST-1:0]  dst_avail,
    output logic [N_DST-1:0]  out_valid,
    input  logic [N_DST-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef RR_DISPATCH_SEQ_EN
   ,output logic [SEQ_W-1:0]  out_seq
`endif
);

    localparam logic [N_DST-1:0] C_LAST_RST = {1'b1, {(N_DST-1){1'b0}}};

    logic [N_DST-1:0]  r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [N_DST-1:0]  r_last;
    logic [N_DST-1:0]  w_pick;
    logic              w_drain;
    logic              w_free;
    logic              w_load;

    rr_select #(
        .N (N_DST)
    ) u_select (
        .avail (dst_avail),
        .last  (r_last),
        .pick  (w_pick)
    );

    always_comb begin
        w_drain  = |(r_out_valid & out_ready);
        w_free   = ~(|r_out_valid) | w_drain;
        in_ready = w_free & (|dst_avail);
        w_load   = in_valid & in_ready;
    end

    // A load overrides a drain so the new beat replaces the old with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_last      <= C_LAST_RST;
        end else if (w_load) begin
            r_out_valid <= w_pick;
            r_out_data  <= in_data;
            r_last      <= w_pick;
        end else if (w_drain) begin
            r_out_valid <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef RR_DISPATCH_SEQ_EN
    logic [SEQ_W-1:0] r_seq_cnt;
    logic [SEQ_W-1:0] r_out_seq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq_cnt <= '0;
            r_out_seq <= '0;
        end else if (w_load) begin
            r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            r_out_seq <= r_seq_cnt;
        end
    end

    assign out_seq = r_out_seq;
`endif

endmodule
`default_nettype wire
